// File: rtl/r_buffer.sv
// r_buffer: AXI R-channel beat buffer with occupancy status and an optional
// per-burst store-and-forward presentation mode.
module r_buffer #(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 4,
  parameter int AFULL_THRESH = DEPTH - 1,
  parameter int STORE_FWD    = 0,
  localparam int PTR_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,
  input  logic [ID_WIDTH-1:0]   S_RID,
  input  logic [DATA_WIDTH-1:0] S_RDATA,
  input  logic [1:0]            S_RRESP,
  input  logic                  S_RLAST,
  input  logic                  S_RVALID,
  output logic                  S_RREADY,
  output logic [ID_WIDTH-1:0]   M_RID,
  output logic [DATA_WIDTH-1:0] M_RDATA,
  output logic [1:0]            M_RRESP,
  output logic                  M_RLAST,
  output logic                  M_RVALID,
  input  logic                  M_RREADY,
  output logic [CNT_W-1:0]      count,
  output logic [CNT_W-1:0]      bursts,
  output logic                  almost_full
);

  localparam int ENTRY_W = ID_WIDTH + DATA_WIDTH + 3;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_CNT = CNT_W'(AFULL_THRESH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               push;
  logic               pop;
  logic               last_push;
  logic               last_pop;

  // Handshake qualification and status flags, all from registered state.
  always_comb begin
    S_RREADY = ARESETn & (count != FULL_CNT);
    if (STORE_FWD != 0)
      M_RVALID = (bursts != '0) | (count == FULL_CNT);
    else
      M_RVALID = (count != '0);
    {M_RID, M_RDATA, M_RRESP, M_RLAST} = mem[rd_ptr];
    push        = S_RVALID & S_RREADY;
    pop         = M_RVALID & M_RREADY;
    last_push   = push & S_RLAST;
    last_pop    = pop & M_RLAST;
    almost_full = (count >= AFULL_CNT);
  end

  // Storage, pointers with explicit wrap, beat and burst counters.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      bursts <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {S_RID, S_RDATA, S_RRESP, S_RLAST};
        wr_ptr      <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      case ({last_push, last_pop})
        2'b10:   bursts <= bursts + 1'b1;
        2'b01:   bursts <= bursts - 1'b1;
        default: bursts <= bursts;
      endcase
    end
  end

endmodule
